// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// mem_access_unit
// Performs a 64-bit load/store as eight little-endian byte beats on a
// byte-wide memory port and returns the data (or a range error) as a pulse.
// Revision: 1.0
// ============================================================================
module mem_access_unit #(
   parameter int MEM_BYTES  = 32,
   parameter int WORD_BYTES = 8
) (
   input  logic        clock,
   input  logic        resetn,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [63:0] req_addr,
   input  logic [63:0] req_wdata,
   output logic        resp_valid,
   output logic [63:0] resp_rdata,
   output logic        resp_error,
   output logic [63:0] mem_addr,
   output logic [7:0]  mem_wdata,
   output logic        mem_we,
   output logic        mem_re,
   input  logic [7:0]  mem_rdata
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      XFER = 2'd1,
      RESP = 2'd2,
      ERR  = 2'd3
   } state_t;

   localparam logic [63:0] LAST_BASE = 64'(MEM_BYTES - WORD_BYTES);

   state_t      state;
   state_t      state_nx;
   logic [2:0]  cnt;
   logic        wr_q;
   logic        err_q;
   logic [63:0] addr_q;
   logic [63:0] wdata_q;
   logic        addr_bad;
   logic [5:0]  lane;

   // Unsigned compare also rejects bases whose last byte would wrap past 2^64
   assign addr_bad   = (req_addr > LAST_BASE);
   assign lane       = {cnt, 3'b000};
   assign resp_error = err_q;

   always_ff @(posedge clock) begin
      if (!resetn) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx   = state;
      req_ready  = 1'b0;
      resp_valid = 1'b0;
      mem_addr   = 64'd0;
      mem_wdata  = 8'd0;
      mem_we     = 1'b0;
      mem_re     = 1'b0;
      case (state)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               state_nx = addr_bad ? ERR : XFER;
            end
         end
         XFER: begin
            mem_addr  = addr_q + {61'd0, cnt};
            mem_we    = wr_q;
            mem_re    = !wr_q;
            mem_wdata = wr_q ? wdata_q[lane +: 8] : 8'd0;
            if (cnt == 3'd7) begin
               state_nx = RESP;
            end
         end
         RESP: begin
            resp_valid = 1'b1;
            state_nx   = IDLE;
         end
         ERR: begin
            resp_valid = 1'b1;
            state_nx   = IDLE;
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (!resetn) begin
         cnt        <= 3'd0;
         wr_q       <= 1'b0;
         err_q      <= 1'b0;
         addr_q     <= 64'd0;
         wdata_q    <= 64'd0;
         resp_rdata <= 64'd0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  wr_q       <= req_write;
                  addr_q     <= req_addr;
                  wdata_q    <= req_wdata;
                  err_q      <= addr_bad;
                  resp_rdata <= 64'd0;
                  cnt        <= 3'd0;
               end
            end
            XFER: begin
               if (!wr_q) begin
                  resp_rdata[lane +: 8] <= mem_rdata;
               end
               cnt <= cnt + 3'd1;
            end
            default: begin
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
// tb_mem_access_unit
// Directed stimulus with a queue-based response scoreboard and byte memory model.
// Revision: 1.0
// ============================================================================
module tb_mem_access_unit;

   logic        clock = 1'b0;
   logic        resetn = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_write = 1'b0;
   logic [63:0] req_addr = 64'd0;
   logic [63:0] req_wdata = 64'd0;
   logic        req_ready;
   logic        resp_valid;
   logic [63:0] resp_rdata;
   logic        resp_error;
   logic [63:0] mem_addr;
   logic [7:0]  mem_wdata;
   logic        mem_we;
   logic        mem_re;
   logic [7:0]  mem_rdata;

   logic [7:0]  mem [0:31] = '{default: 8'h00};

   typedef struct {
      int          at;
      logic        err;
      logic [63:0] data;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   cyc = 0;
   int   n_checks = 0;
   int   n_fail = 0;
   int   we_cnt = 0;
   int   re_cnt = 0;

   localparam logic [63:0] W1 = 64'h1122334455667788;
   localparam logic [63:0] W2 = 64'hA5A50000FFFF0001;

   mem_access_unit #(.MEM_BYTES(32), .WORD_BYTES(8)) dut (
      .clock      (clock),
      .resetn     (resetn),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_write  (req_write),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .resp_valid (resp_valid),
      .resp_rdata (resp_rdata),
      .resp_error (resp_error),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_we     (mem_we),
      .mem_re     (mem_re),
      .mem_rdata  (mem_rdata)
   );

   always #5 clock = ~clock;

   always @(posedge clock) begin
      cyc <= cyc + 1;
      if (mem_we && mem_addr < 64'd32) mem[mem_addr[4:0]] <= mem_wdata;
   end

   assign mem_rdata = (mem_addr < 64'd32) ? mem[mem_addr[4:0]] : 8'h00;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: pops the scoreboard whenever the DUT presents a response
   always @(negedge clock) begin
      if (mem_we) we_cnt++;
      if (mem_re) re_cnt++;
      if (resp_valid) begin
         if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_resp: got rdata %h error %b, required no response (cycle %0d)",
                     resp_rdata, resp_error, cyc);
         end else begin
            mon_e = sb.pop_front();
            check("resp_cycle", 64'(cyc), 64'(mon_e.at));
            check("resp_error", {63'd0, resp_error}, {63'd0, mon_e.err});
            check("resp_rdata", resp_rdata, mon_e.data);
         end
      end
   end

   task automatic issue(input logic wr, input logic [63:0] addr, input logic [63:0] wdata,
                        input logic exp_err, input logic [63:0] exp_data,
                        input bit expect_resp, output int acc);
      int   guard;
      exp_t e;
      guard = 0;
      @(negedge clock);
      while (!req_ready && guard < 50) begin
         @(negedge clock);
         guard++;
      end
      if (!req_ready) begin
         n_checks++;
         n_fail++;
         $display("FAIL ready_timeout: got req_ready 0 required 1");
      end
      req_valid = 1'b1;
      req_write = wr;
      req_addr  = addr;
      req_wdata = wdata;
      acc = cyc + 1;
      if (expect_resp) begin
         e.at   = acc + (exp_err ? 0 : 8);
         e.err  = exp_err;
         e.data = exp_data;
         sb.push_back(e);
      end
      @(negedge clock);
      req_valid = 1'b0;
   endtask

   task automatic wait_done();
      int g;
      g = 0;
      while (sb.size() != 0 && g < 40) begin
         @(negedge clock);
         g++;
      end
      if (sb.size() != 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL resp_timeout: got %0d pending responses required 0", sb.size());
         sb.delete();
      end
      @(negedge clock);
   endtask

   initial begin
      int   a;
      int   a2;
      int   we0;
      int   re0;
      exp_t e;

      // Reset with a request pending: it must not be taken
      req_valid = 1'b1;
      repeat (3) @(negedge clock);
      check("rst_req_ready", {63'd0, req_ready}, 64'd1);
      check("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
      check("rst_resp_error", {63'd0, resp_error}, 64'd0);
      check("rst_resp_rdata", resp_rdata, 64'd0);
      check("rst_mem_addr", mem_addr, 64'd0);
      check("rst_mem_wdata", {56'd0, mem_wdata}, 64'd0);
      check("rst_mem_we", {63'd0, mem_we}, 64'd0);
      check("rst_mem_re", {63'd0, mem_re}, 64'd0);
      req_valid = 1'b0;
      resetn = 1'b1;
      @(negedge clock);

      // Store W1 at 0, checking every byte beat
      issue(1'b1, 64'd0, W1, 1'b0, 64'd0, 1'b1, a);
      for (int i = 0; i < 8; i++) begin
         check("st_mem_we", {63'd0, mem_we}, 64'd1);
         check("st_mem_re", {63'd0, mem_re}, 64'd0);
         check("st_mem_addr", mem_addr, 64'(i));
         check("st_mem_wdata", {56'd0, mem_wdata}, {56'd0, W1[8*i +: 8]});
         if (i < 7) @(negedge clock);
      end
      wait_done();
      issue(1'b0, 64'd0, 64'd0, 1'b0, W1, 1'b1, a);
      wait_done();

      // Top-of-range base, then just past it
      issue(1'b1, 64'd24, W2, 1'b0, 64'd0, 1'b1, a);
      wait_done();
      issue(1'b0, 64'd24, 64'd0, 1'b0, W2, 1'b1, a);
      wait_done();
      we0 = we_cnt;
      re0 = re_cnt;
      issue(1'b1, 64'd25, 64'hDEADBEEFDEADBEEF, 1'b1, 64'd0, 1'b1, a);
      wait_done();
      issue(1'b0, 64'hFFFF_FFFF_FFFF_FFFC, 64'd0, 1'b1, 64'd0, 1'b1, a);
      wait_done();
      check("err_no_we", 64'(we_cnt), 64'(we0));
      check("err_no_re", 64'(re_cnt), 64'(re0));

      // req_valid held high; busy-time requests must be ignored
      we0 = we_cnt;
      @(negedge clock);
      req_valid = 1'b1;
      req_write = 1'b0;
      req_addr  = 64'd0;
      req_wdata = 64'd0;
      a = cyc + 1;
      e.at = a + 8; e.err = 1'b0; e.data = W1;
      sb.push_back(e);
      for (int k = 0; k < 9; k++) begin
         @(negedge clock);
         check("hs_ready_busy", {63'd0, req_ready}, 64'd0);
         req_write = (k % 2 == 0);
         req_addr  = (k % 2 == 0) ? 64'd25 : 64'd16;
         req_wdata = {64{1'b1}};
      end
      @(negedge clock);
      check("hs_ready_again", {63'd0, req_ready}, 64'd1);
      req_write = 1'b0;
      req_addr  = 64'd24;
      e.at = a + 18; e.err = 1'b0; e.data = W2;
      sb.push_back(e);
      @(negedge clock);
      check("hs_second_accept", {63'd0, req_ready}, 64'd0);
      req_valid = 1'b0;
      wait_done();
      check("hs_no_we", 64'(we_cnt), 64'(we0));

      // Reset sampled at the edge ending beat 3 of a store
      issue(1'b1, 64'd8, {64{1'b1}}, 1'b0, 64'd0, 1'b0, a);
      repeat (3) @(negedge clock);
      resetn = 1'b0;
      @(negedge clock);
      check("mrst_req_ready", {63'd0, req_ready}, 64'd1);
      check("mrst_resp_valid", {63'd0, resp_valid}, 64'd0);
      check("mrst_mem_we", {63'd0, mem_we}, 64'd0);
      check("mrst_mem_addr", mem_addr, 64'd0);
      check("mrst_resp_rdata", resp_rdata, 64'd0);
      resetn = 1'b1;
      issue(1'b0, 64'd8, 64'd0, 1'b0, 64'h0000_0000_FFFF_FFFF, 1'b1, a);
      wait_done();

      // Back-to-back loads over a counting pattern
      issue(1'b1, 64'd0, 64'h0706050403020100, 1'b0, 64'd0, 1'b1, a);
      issue(1'b1, 64'd8, 64'h0F0E0D0C0B0A0908, 1'b0, 64'd0, 1'b1, a);
      wait_done();
      issue(1'b0, 64'd0, 64'd0, 1'b0, 64'h0706050403020100, 1'b1, a);
      issue(1'b0, 64'd8, 64'd0, 1'b0, 64'h0F0E0D0C0B0A0908, 1'b1, a2);
      check("b2b_accept_gap", 64'(a2 - a), 64'd10);
      check("b2b_rdata_cleared", resp_rdata, 64'd0);
      wait_done();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL global_timeout: got cycle %0d required test end", cyc);
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Initiator side of the data-memory interface.
- Accepts one 64-bit load or store request per transaction from the CPU memory stage.
- Performs the access as 8 sequential byte beats on a byte-wide memory port, in little-endian order (byte 0 at the lowest address).
- Returns the assembled load data, or an out-of-range error, with a one-cycle response pulse.

Parameters:
- MEM_BYTES, 32: size of the addressed memory in bytes; valid word base addresses are 0..MEM_BYTES-8.
- WORD_BYTES, 8: bytes per access. Fixed at 8; other values are unsupported.

Ports:
- clock  in  1  — sole clock, rising edge.
- resetn  in  1  — synchronous, active-low reset.
- req_valid  in  1  — request present.
- req_ready  out  1  — unit can accept a request.
- req_write  in  1  — 1 = store, 0 = load.
- req_addr  in  64  — byte base address.
- req_wdata  in  64  — store data.
- resp_valid  out  1  — one-cycle response pulse.
- resp_rdata  out  64  — load data.
- resp_error  out  1  — address out of range; qualified by resp_valid.
- mem_addr  out  64  — byte address to memory.
- mem_wdata  out  8  — byte to write.
- mem_we  out  1  — byte write strobe; memory writes at the clock edge.
- mem_re  out  1  — byte read strobe.
- mem_rdata  in  8  — combinational read data for mem_addr, valid in the same cycle.

Behaviour:
- Clock and reset: one clock (clock); reset is synchronous and active-low (resetn). Sampled only at the rising edge of clock.
- Reset values: state=IDLE, req_ready=1, resp_valid=0, resp_error=0, resp_rdata=0, mem_addr=0, mem_wdata=0, mem_we=0, mem_re=0, beat counter=0.
- IDLE:
  - req_ready=1; all mem strobes are 0.
  - Accept on the edge where req_valid&&req_ready. At that edge, latch write, addr and wdata, clear resp_rdata, and clear the counter.
  - Range check at accept: error if req_addr > MEM_BYTES-8, evaluated as an unsigned 64-bit compare (this also covers wrap-around).
  - In range → XFER. Out of range → ERR.
- XFER:
  - req_ready=0; beats counted cnt=0..7.
  - Combinational outputs per beat: mem_addr = latched addr + cnt; mem_we = write; mem_re = !write; mem_wdata = wdata[8*cnt+7 : 8*cnt] (0 on loads).
  - Load: at each edge, resp_rdata[8*cnt+7 : 8*cnt] <= mem_rdata.
  - At the edge ending cnt=7 → RESP; otherwise cnt increments.
- RESP:
  - resp_valid=1 and resp_error=0 for exactly one cycle; no backpressure.
  - resp_rdata = assembled word on loads, 0 on stores.
  - Next state is IDLE.
- ERR:
  - resp_valid=1 and resp_error=1 for one cycle; resp_rdata=0.
  - No mem strobe is asserted at any time for the transaction.
  - Next state is IDLE.
- Latency:
  - Accept at edge E0 → beats occupy the 8 cycles after E0 → resp_valid in the 9th cycle after E0.
  - Error response: resp_valid in the cycle immediately after E0.
  - Next request can be accepted at the edge ending the response cycle's following IDLE cycle, i.e. 10 cycles per in-range transaction.
- Request inputs are ignored outside IDLE; no queuing.
- Holding: resp_rdata holds its value after RESP until the next accept. resp_error holds likewise, but is meaningful only with resp_valid.
- Misaligned bases are legal when in range (e.g. addr=3 accesses bytes 3..10).
- Reset mid-transaction: at the sampled edge, state returns to IDLE and all outputs take reset values. No response is issued. Bytes already written stay written; no rollback.
- req_valid=1 on the same edge that resetn=0: the request is not accepted.

Test Plan:
- Store then load: store addr=0, wdata=0x1122334455667788 → mem_we for 8 cycles, mem_addr 0..7, mem_wdata 0x88,0x77,…,0x11; load addr=0 → resp_rdata=0x1122334455667788, resp_error=0, resp_valid exactly 9 cycles after accept.
- Misaligned top-of-range: store addr=24 (MEM_BYTES-8), wdata=0xA5A5_0000_FFFF_0001 → load addr=24 returns the same value; addr=25 → ERR pulse, resp_error=1, no mem_we/mem_re ever asserted.
- Wrap: load addr=0xFFFF_FFFF_FFFF_FFFC → resp_error=1 one cycle after accept, resp_rdata=0.
- Handshake: req_valid held high continuously with alternating requests → req_ready low from accept through RESP; second accept occurs exactly 10 cycles after the first; requests during XFER are ignored.
- Reset mid-store: store 0xFFFF_FFFF_FFFF_FFFF to addr=8, with resetn=0 sampled at the edge ending beat 3 → no resp_valid; all outputs return to reset values. A subsequent load of addr=8 (memory pre-zeroed) returns 0x0000_0000_FFFF_FFFF.
- Back-to-back loads: load addr=0 then addr=8 with memory bytes 0..15 = 0x00..0x0F → responses 0x0706050403020100 then 0x0F0E0D0C0B0A0908; resp_rdata reads 0 between the second accept and its RESP.
